hs32_decode_exec: RTL and testbench

- Combined decode + execute slice of the HS32 core.
- Accepts one 32-bit instruction word at a time from fetch and decodes it.
- Executes the instruction against a 16x32 register file, using the ALU or a single-beat memory access.
- Sits between the fetch unit and the memory controller.
- Advances an internal program counter by 4 per retired instruction.

---
 rtl/hs32_decode_exec.sv | 129 ++++++++++++
 tb/tb_hs32_decode_exec.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hs32_decode_exec.sv
// HS32 decode + execute slice: latches one instruction from fetch, executes it against
// a 16x32 register file through the ALU or a single-beat memory access, and advances pc.
module hs32_decode_exec #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instf,
    input  logic        rdyd,
    output logic        reqd,
    output logic [31:0] addr,
    input  logic [31:0] dtrm,
    output logic [31:0] dtwm,
    output logic        reqm,
    input  logic        rdym,
    output logic        rw_mem,
    output logic [31:0] pc,
    input  logic [3:0]  dbg_sel,
    output logic [31:0] dbg_data
);

    typedef enum logic [1:0] {IDLE, EXEC, MEM} state_t;

    localparam logic [3:0] CLS_LDR = 4'h1;
    localparam logic [3:0] CLS_MOV = 4'h2;
    localparam logic [3:0] CLS_STR = 4'h3;
    localparam logic [3:0] CLS_ADD = 4'h4;
    localparam logic [3:0] CLS_SUB = 4'h5;
    localparam logic [3:0] CLS_AND = 4'h6;
    localparam logic [3:0] CLS_OR  = 4'h7;
    localparam logic [3:0] CLS_XOR = 4'h8;

    state_t      state;
    state_t      state_next;
    logic [31:0] inst;
    logic [31:0] regs [16];

    logic [7:0]  op;
    logic [3:0]  cls;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [3:0]  rn;
    logic [4:0]  sh;
    logic [31:0] imm;
    logic [31:0] operand_b;
    logic [31:0] alu_result;
    logic        alu_write;
    logic        is_mem;
    logic        unused_op_bits;

    assign op    = inst[31:24];
    assign cls   = op[7:4];
    assign rd    = inst[23:20];
    assign rm    = inst[19:16];
    assign rn    = inst[15:12];
    assign sh    = inst[11:7];
    assign imm   = {16'h0000, inst[15:0]};
    assign is_mem = (cls == CLS_LDR) || (cls == CLS_STR);
    assign unused_op_bits = ^{op[3], op[1:0]};

    assign operand_b = op[2] ? imm : (regs[rn] << sh);

    always_comb begin
        alu_result = '0;
        alu_write  = 1'b1;
        case (cls)
            CLS_MOV: alu_result = operand_b;
            CLS_ADD: alu_result = regs[rm] + operand_b;
            CLS_SUB: alu_result = regs[rm] - operand_b;
            CLS_AND: alu_result = regs[rm] & operand_b;
            CLS_OR:  alu_result = regs[rm] | operand_b;
            CLS_XOR: alu_result = regs[rm] ^ operand_b;
            default: alu_write  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rdyd) state_next = EXEC;
            EXEC:    state_next = is_mem ? MEM : IDLE;
            MEM:     if (rdym) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // reqd is gated by reset so fetch never sees an accept while the block is held in reset.
    assign reqd     = reset && (state == IDLE);
    assign reqm     = (state == MEM);
    assign dbg_data = regs[dbg_sel];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst   <= '0;
            pc     <= RESET_PC;
            addr   <= '0;
            dtwm   <= '0;
            rw_mem <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            case (state)
                IDLE: if (rdyd) inst <= instf;
                EXEC: begin
                    if (is_mem) begin
                        addr   <= regs[rm] + imm;
                        dtwm   <= regs[rd];
                        rw_mem <= (cls == CLS_STR);
                    end else begin
                        if (alu_write) regs[rd] <= alu_result;
                        pc <= pc + 32'd4;
                    end
                end
                MEM: begin
                    if (rdym) begin
                        if (cls == CLS_LDR) regs[rd] <= dtrm;
                        pc <= pc + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hs32_decode_exec.sv
// Bench for hs32_decode_exec: hand-computed vector table, reset-in-MEM sequence and
// randomized instructions checked against an instruction-level reference model.
`timescale 1ns/1ps
module tb_hs32_decode_exec;

    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;

    logic        clk;
    logic        reset;
    logic [31:0] instf;
    logic        rdyd;
    logic        reqd;
    logic [31:0] addr;
    logic [31:0] dtrm;
    logic [31:0] dtwm;
    logic        reqm;
    logic        rdym;
    logic        rw_mem;
    logic [31:0] pc;
    logic [3:0]  dbg_sel;
    logic [31:0] dbg_data;

    int checks;
    int failures;

    logic [31:0] ref_regs [16];
    logic [31:0] ref_pc;

    typedef struct {
        logic [31:0] instr;
        int          waits;
        logic [31:0] rdata;
        logic [3:0]  chk_reg;
        logic [31:0] exp_val;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs [15];

    hs32_decode_exec #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .instf(instf), .rdyd(rdyd), .reqd(reqd),
        .addr(addr), .dtrm(dtrm), .dtwm(dtwm), .reqm(reqm), .rdym(rdym),
        .rw_mem(rw_mem), .pc(pc), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) ref_regs[i] = '0;
        ref_pc = RESET_PC;
    endtask

    // Safe to step dbg_sel across edges: block is idle with rdyd low, so nothing changes.
    task automatic checkState(input string tag);
        for (int i = 0; i < 16; i++) begin
            dbg_sel = 4'(i);
            #1;
            checkOutput($sformatf("%s_r%0d", tag, i), dbg_data, ref_regs[i]);
        end
        checkOutput({tag, "_pc"}, pc, ref_pc);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input int waits, input logic [31:0] rdata,
                                 output logic [31:0] cap_addr, output logic [31:0] cap_wdata,
                                 output logic cap_rw);
        logic [3:0] cls;
        logic       mem;
        int         reqm_cycles;
        cls = instr[31:28];
        mem = (cls == 4'h1) || (cls == 4'h3);
        cap_addr = '0;
        cap_wdata = '0;
        cap_rw = 1'b0;
        checkOutput("reqd_idle", 32'(reqd), 32'd1);
        instf = instr;
        rdyd  = 1'b1;
        @(negedge clk);
        checkOutput("reqd_exec", 32'(reqd), 32'd0);
        checkOutput("reqm_exec", 32'(reqm), 32'd0);
        rdyd  = 1'($urandom % 2);
        instf = $urandom;
        rdym  = 1'($urandom % 2);
        @(negedge clk);
        if (mem) begin
            rdym = 1'b0;
            reqm_cycles = 0;
            cap_addr  = addr;
            cap_wdata = dtwm;
            cap_rw    = rw_mem;
            for (int k = 0; k <= waits; k++) begin
                if (reqm) reqm_cycles++;
                checkOutput("reqd_mem", 32'(reqd), 32'd0);
                checkOutput("addr_hold", addr, cap_addr);
                checkOutput("rw_hold", 32'(rw_mem), 32'(cap_rw));
                if (k == waits) begin
                    rdym = 1'b1;
                    dtrm = rdata;
                end
                @(negedge clk);
                rdym = 1'b0;
            end
            checkOutput("reqm_cycles", 32'(reqm_cycles), 32'(waits + 1));
            dtrm = $urandom;
        end
        rdyd = 1'b0;
        rdym = 1'($urandom % 2);
        checkOutput("reqm_after", 32'(reqm), 32'd0);
        checkOutput("reqd_after", 32'(reqd), 32'd1);
    endtask

    // Instruction-level reference: predicts the memory beat, then retires the instruction.
    task automatic run_one(input logic [31:0] instr, input int waits, input logic [31:0] rdata,
                           output logic [31:0] cap_addr);
        logic [3:0]  cls, rd, rm, rn;
        logic [4:0]  sh;
        logic [31:0] imm, b, a;
        logic [31:0] cap_wdata;
        logic        cap_rw;
        cls = instr[31:28];
        rd  = instr[23:20];
        rm  = instr[19:16];
        rn  = instr[15:12];
        sh  = instr[11:7];
        imm = {16'h0, instr[15:0]};
        a   = ref_regs[rm];
        b   = instr[26] ? imm : (ref_regs[rn] << sh);
        applyStimulus(instr, waits, rdata, cap_addr, cap_wdata, cap_rw);
        if (cls == 4'h1 || cls == 4'h3) begin
            checkOutput("mem_addr", cap_addr, a + imm);
            checkOutput("mem_rw", 32'(cap_rw), (cls == 4'h3) ? 32'd1 : 32'd0);
            if (cls == 4'h3) checkOutput("mem_wdata", cap_wdata, ref_regs[rd]);
        end
        case (cls)
            4'h1: ref_regs[rd] = rdata;
            4'h2: ref_regs[rd] = b;
            4'h4: ref_regs[rd] = a + b;
            4'h5: ref_regs[rd] = a - b;
            4'h6: ref_regs[rd] = a & b;
            4'h7: ref_regs[rd] = a | b;
            4'h8: ref_regs[rd] = a ^ b;
            default: ;
        endcase
        ref_pc = ref_pc + 32'd4;
        checkState("st");
    endtask

    initial begin
        logic [31:0] got_addr;
        logic [31:0] instr;
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        instf    = '0;
        rdyd     = 1'b1;
        dtrm     = '0;
        rdym     = 1'b0;
        dbg_sel  = '0;
        model_reset();

        vecs[0]  = '{32'h2420_4321, 0, 32'h0, 4'd2, 32'h0000_4321, 32'h0};
        vecs[1]  = '{32'h2400_0005, 0, 32'h0, 4'd0, 32'h0000_0005, 32'h0};
        vecs[2]  = '{32'h2410_0001, 0, 32'h0, 4'd1, 32'h0000_0001, 32'h0};
        vecs[3]  = '{32'h4030_1200, 0, 32'h0, 4'd3, 32'h0000_0015, 32'h0};
        vecs[4]  = '{32'h2400_0000, 0, 32'h0, 4'd0, 32'h0000_0000, 32'h0};
        vecs[5]  = '{32'h5440_0001, 0, 32'h0, 4'd4, 32'hFFFF_FFFF, 32'h0};
        vecs[6]  = '{32'h2400_1000, 0, 32'h0, 4'd0, 32'h0000_1000, 32'h0};
        vecs[7]  = '{32'h1450_0010, 3, 32'hCAFE_BABE, 4'd5, 32'hCAFE_BABE, 32'h0000_1010};
        vecs[8]  = '{32'h2460_BBBB, 0, 32'h0, 4'd6, 32'h0000_BBBB, 32'h0};
        vecs[9]  = '{32'h2010_6800, 0, 32'h0, 4'd1, 32'hBBBB_0000, 32'h0};
        vecs[10] = '{32'h7411_BBBB, 0, 32'h0, 4'd1, 32'hBBBB_BBBB, 32'h0};
        vecs[11] = '{32'h3410_0004, 0, 32'h0, 4'd1, 32'hBBBB_BBBB, 32'h0000_1004};
        vecs[12] = '{32'h6471_00FF, 0, 32'h0, 4'd7, 32'h0000_00BB, 32'h0};
        vecs[13] = '{32'h8481_FFFF, 0, 32'h0, 4'd8, 32'hBBBB_4444, 32'h0};
        vecs[14] = '{32'hF000_0000, 0, 32'h0, 4'd8, 32'hBBBB_4444, 32'h0};

        repeat (3) @(negedge clk);
        checkOutput("rst_reqd", 32'(reqd), 32'd0);
        checkOutput("rst_reqm", 32'(reqm), 32'd0);
        checkOutput("rst_rw", 32'(rw_mem), 32'd0);
        checkOutput("rst_addr", addr, 32'h0);
        checkOutput("rst_dtwm", dtwm, 32'h0);
        checkOutput("rst_pc", pc, RESET_PC);
        rdyd  = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checkState("rst");

        for (int i = 0; i < 15; i++) begin
            run_one(vecs[i].instr, vecs[i].waits, vecs[i].rdata, got_addr);
            dbg_sel = vecs[i].chk_reg;
            #1;
            checkOutput($sformatf("tbl%0d_reg", i), dbg_data, vecs[i].exp_val);
            if (vecs[i].exp_addr != 32'h0) checkOutput($sformatf("tbl%0d_addr", i), got_addr, vecs[i].exp_addr);
            if (i == 0) checkOutput("tbl0_pc", pc, RESET_PC + 32'd4);
            @(negedge clk);
        end

        // Reset asserted while waiting in MEM must abandon the load and drop reqm at once.
        instf = 32'h1450_0010;
        rdyd  = 1'b1;
        @(negedge clk);
        rdyd  = 1'b0;
        rdym  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("midmem_reqm_before", 32'(reqm), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("midmem_reqm_async", 32'(reqm), 32'd0);
        checkOutput("midmem_reqd", 32'(reqd), 32'd0);
        model_reset();
        @(negedge clk);
        rdym  = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        rdym  = 1'b0;
        checkState("midmem");
        run_one(32'hF000_0000, 0, 32'h0, got_addr);
        checkOutput("nop_pc", pc, RESET_PC + 32'd4);

        for (int n = 0; n < 300; n++) begin
            instr = $urandom;
            instr[31:28] = 4'($urandom_range(0, 9));
            run_one(instr, int'($urandom_range(0, 3)), $urandom, got_addr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
